// File: rtl/mine_map_pkg.sv
// mine_map_pkg: shared types and constants for the dot-matrix frame writer.
//   state_t    : writer FSM states
//   op_t       : cell-write operation codes carried with each key request
//   popcount16 : lit-pixel count of one frame row
package mine_map_pkg;

   localparam int FRAME_ROWS = 8;
   localparam int FRAME_COLS = 16;
   localparam int AREA_DIM   = 4;
   localparam int SCAN_SLOTS = 9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      ACK   = 2'd2,
      CLEAR = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OP_SET = 2'b00,
      OP_CLR = 2'b01,
      OP_TGL = 2'b10,
      OP_NOP = 2'b11
   } op_t;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < 16; i++) begin
         n = n + {4'b0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/mine_map_writer_if.sv
// mine_map_writer_if: 4-phase cell-write handshake from the keypad path.
//   key_req   : request, held until key_ack rises, then dropped
//   key_index : cell within the 4x4 area
//   area      : area 0..7 (2 area-rows x 4 area-cols)
//   op        : set / clear / toggle / no-op
//   key_ack   : acknowledge, follows key_req after the write completes
// master = keypad side, slave = frame writer.
interface mine_map_writer_if;
   logic       key_req;
   logic [3:0] key_index;
   logic [2:0] area;
   logic [1:0] op;
   logic       key_ack;

   modport master (output key_req, output key_index, output area, output op, input key_ack);
   modport slave  (input key_req, input key_index, input area, input op, output key_ack);
endinterface

// File: rtl/mine_map_writer_dot_row_scan.sv
// dot_row_scan: read side of the frame. Walks 9 slots (8 rows + 1 blank)
// and drives the matrix pins from registers.
//   div_clk_10k : block clock
//   reset       : asynchronous, active-low
//   frame       : 8 rows x 16 columns of pixel state
//   dotR        : active-low row select (slot k drives bit 7-k low)
//   dotC        : column data of the selected row, 0 in the blank slot
module dot_row_scan
   import mine_map_pkg::*;
(
   input  logic                                  div_clk_10k,
   input  logic                                  reset,
   input  logic [FRAME_ROWS-1:0][FRAME_COLS-1:0] frame,
   output logic [7:0]                            dotR,
   output logic [15:0]                           dotC
);

   logic [3:0] slot;

   // Pins are registered so that reset forces them blank and slot 0
   // appears on the first edge after release.
   always_ff @(posedge div_clk_10k or negedge reset) begin
      if (!reset) begin
         slot <= '0;
         dotR <= 8'hFF;
         dotC <= '0;
      end else if (slot == 4'(SCAN_SLOTS - 1)) begin
         slot <= '0;
         dotR <= 8'hFF;
         dotC <= '0;
      end else begin
         slot <= slot + 4'd1;
         dotR <= ~(8'h80 >> slot[2:0]);
         dotC <= frame[slot[2:0]];
      end
   end

endmodule

// File: rtl/mine_map_writer.sv
// mine_map_writer: write side of the 8x16 LED dot matrix.
//   div_clk_10k : block clock (10 kHz)
//   reset       : asynchronous, active-low
//   key_bus     : cell-write handshake (slave side)
//   clear_all   : asynchronous level; each rising edge wipes the frame
//   busy        : high in WRITE, ACK and CLEAR
//   set_count   : number of lit pixels, 0..128
//   dotR, dotC  : matrix row select (active-low) and column data
//
// state | meaning
// IDLE  | waiting for a clear (has priority) or a synchronized key request
// WRITE | one-cycle read-modify-write of the target pixel
// ACK   | key_ack high until the synchronized request drops
// CLEAR | zero one row per cycle, rows 0..7
module mine_map_writer
   import mine_map_pkg::*;
(
   input  logic                     div_clk_10k,
   input  logic                     reset,
   mine_map_writer_if.slave         key_bus,
   input  logic                     clear_all,
   output logic                     busy,
   output logic [7:0]               set_count,
   output logic [7:0]               dotR,
   output logic [15:0]              dotC
);

   logic [FRAME_ROWS-1:0][FRAME_COLS-1:0] frame;

   state_t     state;
   logic       req_m, req_s;
   logic       clr_m, clr_s, clr_s_d;
   logic       clr_rise;
   logic       clr_pend;
   logic [2:0] clr_row;
   logic       key_ack_r;

   logic [2:0] tgt_row;
   logic [3:0] tgt_col;
   logic       old_bit;
   logic       new_bit;
   logic [7:0] cnt_next;

   assign key_bus.key_ack = key_ack_r;

   always_ff @(posedge div_clk_10k or negedge reset) begin
      if (!reset) begin
         req_m   <= 1'b0;
         req_s   <= 1'b0;
         clr_m   <= 1'b0;
         clr_s   <= 1'b0;
         clr_s_d <= 1'b0;
      end else begin
         req_m   <= key_bus.key_req;
         req_s   <= req_m;
         clr_m   <= clear_all;
         clr_s   <= clr_m;
         clr_s_d <= clr_s;
      end
   end

   assign clr_rise = clr_s & ~clr_s_d;

   // row = 4*area_row + cell_row, col = 4*area_col + cell_col
   assign tgt_row = {key_bus.area[2], key_bus.key_index[3:2]};
   assign tgt_col = {key_bus.area[1:0], key_bus.key_index[1:0]};
   assign old_bit = frame[tgt_row][tgt_col];

   always_comb begin
      new_bit  = old_bit;
      cnt_next = set_count;
      case (op_t'(key_bus.op))
         OP_SET: begin
            new_bit  = 1'b1;
            cnt_next = old_bit ? set_count : set_count + 8'd1;
         end
         OP_CLR: begin
            new_bit  = 1'b0;
            cnt_next = old_bit ? set_count - 8'd1 : set_count;
         end
         OP_TGL: begin
            new_bit  = ~old_bit;
            cnt_next = old_bit ? set_count - 8'd1 : set_count + 8'd1;
         end
         default: begin
            new_bit  = old_bit;
            cnt_next = set_count;
         end
      endcase
   end

   always_ff @(posedge div_clk_10k or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         frame     <= '0;
         set_count <= '0;
         clr_pend  <= 1'b0;
         clr_row   <= '0;
         busy      <= 1'b0;
         key_ack_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (clr_pend || clr_rise) begin
                  state    <= CLEAR;
                  clr_pend <= 1'b0;
                  clr_row  <= '0;
                  busy     <= 1'b1;
               end else if (req_s) begin
                  state <= WRITE;
                  busy  <= 1'b1;
               end
            end
            WRITE: begin
               frame[tgt_row][tgt_col] <= new_bit;
               set_count               <= cnt_next;
               state                   <= ACK;
               key_ack_r               <= 1'b1;
               if (clr_rise) clr_pend <= 1'b1;
            end
            ACK: begin
               if (!req_s) begin
                  state     <= IDLE;
                  key_ack_r <= 1'b0;
                  busy      <= 1'b0;
               end
               if (clr_rise) clr_pend <= 1'b1;
            end
            CLEAR: begin
               frame[clr_row] <= '0;
               // Subtract the row being wiped so the count tracks the frame
               // during the clear; it lands on 0 with the last row.
               if (clr_row == 3'(FRAME_ROWS - 1)) begin
                  set_count <= '0;
                  state     <= IDLE;
                  busy      <= 1'b0;
               end else begin
                  set_count <= set_count - {3'b0, popcount16(frame[clr_row])};
                  clr_row   <= clr_row + 3'd1;
               end
               if (clr_rise) clr_pend <= 1'b1;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   dot_row_scan u_scan (
      .div_clk_10k (div_clk_10k),
      .reset       (reset),
      .frame       (frame),
      .dotR        (dotR),
      .dotC        (dotC)
   );

endmodule

// File: tb/tb_mine_map_writer.sv
// tb_mine_map_writer: table-driven, hand-sequenced and randomized checks of
// mine_map_writer against a flat 128-pixel reference array.
module tb_mine_map_writer;
   import mine_map_pkg::*;

   logic        div_clk_10k = 1'b0;
   logic        reset       = 1'b0;
   logic        clear_all   = 1'b0;
   logic        busy;
   logic [7:0]  set_count;
   logic [7:0]  dotR;
   logic [15:0] dotC;

   mine_map_writer_if kb ();

   mine_map_writer dut (
      .div_clk_10k (div_clk_10k),
      .reset       (reset),
      .key_bus     (kb),
      .clear_all   (clear_all),
      .busy        (busy),
      .set_count   (set_count),
      .dotR        (dotR),
      .dotC        (dotC)
   );

   always #5 div_clk_10k = ~div_clk_10k;

   int vec_cnt  = 0;
   int miss_cnt = 0;
   bit model [128];

   typedef struct {
      int          area;
      int          idx;
      int          op;
      int          row;
      logic [15:0] exp_row;
      int          exp_cnt;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_count();
      int n = 0;
      for (int i = 0; i < 128; i++) n += model[i] ? 1 : 0;
      return n;
   endfunction

   function automatic logic [15:0] model_row(input int r);
      logic [15:0] v = '0;
      for (int c = 0; c < 16; c++) v[c] = model[16 * r + c];
      return v;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 128; i++) model[i] = 1'b0;
   endtask

   task automatic model_apply(input int a, input int idx, input int op);
      int p;
      p = 16 * (4 * (a / 4) + idx / 4) + 4 * (a % 4) + idx % 4;
      case (op)
         0: model[p] = 1'b1;
         1: model[p] = 1'b0;
         2: model[p] = ~model[p];
         default: ;
      endcase
   endtask

   task automatic start_req(input int a, input int idx, input int op);
      @(negedge div_clk_10k);
      kb.area      = 3'(a);
      kb.key_index = 4'(idx);
      kb.op        = 2'(op);
      kb.key_req   = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(posedge div_clk_10k); #1;
         chk("ack_rise", {31'b0, kb.key_ack}, (i == 4) ? 1 : 0);
         chk("busy_write", {31'b0, busy}, (i >= 3) ? 1 : 0);
      end
      model_apply(a, idx, op);
   endtask

   task automatic handshake(input int a, input int idx, input int op);
      start_req(a, idx, op);
      @(negedge div_clk_10k);
      kb.key_req = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         @(posedge div_clk_10k); #1;
         chk("ack_fall", {31'b0, kb.key_ack}, (i < 3) ? 1 : 0);
      end
   endtask

   task automatic read_row(input int r, output logic [15:0] v);
      logic [7:0] sel;
      bit found;
      sel   = 8'h80 >> r;
      found = 0;
      v     = 'x;
      for (int t = 0; t < 30 && !found; t++) begin
         @(negedge div_clk_10k);
         if (dotR == ~sel) begin
            found = 1;
            v     = dotC;
         end
      end
      if (!found) chk("row_timeout", 0, 1);
   endtask

   task automatic check_frame();
      logic [15:0] v;
      for (int r = 0; r < 8; r++) begin
         read_row(r, v);
         chk($sformatf("frame_row%0d", r), {16'b0, v}, {16'b0, model_row(r)});
      end
      chk("set_count_frame", {24'b0, set_count}, model_count());
   endtask

   task automatic count_busy(input int edges, output int n);
      n = 0;
      for (int i = 0; i < edges; i++) begin
         @(posedge div_clk_10k); #1;
         if (busy) n++;
      end
   endtask

   vec_t tbl [9];

   initial begin
      int n;
      int a, idx, op;

      tbl[0] = '{0, 0, 0, 0, 16'h0001, 1};
      tbl[1] = '{7, 15, 2, 7, 16'h8000, 2};
      tbl[2] = '{7, 15, 2, 7, 16'h0000, 1};
      tbl[3] = '{5, 6, 0, 5, 16'h0040, 2};
      tbl[4] = '{5, 6, 0, 5, 16'h0040, 2};
      tbl[5] = '{5, 6, 3, 5, 16'h0040, 2};
      tbl[6] = '{5, 6, 1, 5, 16'h0000, 1};
      tbl[7] = '{0, 0, 1, 0, 16'h0000, 0};
      tbl[8] = '{0, 0, 1, 0, 16'h0000, 0};

      kb.key_req   = 1'b0;
      kb.key_index = '0;
      kb.area      = '0;
      kb.op        = '0;
      model_clear();

      // Reset state
      repeat (3) @(posedge div_clk_10k);
      #1;
      chk("rst_dotR", {24'b0, dotR}, 32'hFF);
      chk("rst_dotC", {16'b0, dotC}, 0);
      chk("rst_count", {24'b0, set_count}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_ack", {31'b0, kb.key_ack}, 0);

      // Scan sequence after release
      @(negedge div_clk_10k);
      reset = 1'b1;
      for (int k = 0; k < 9; k++) begin
         logic [7:0] sel;
         sel = 8'h80 >> k;
         @(posedge div_clk_10k); #1;
         chk("scan_dotR", {24'b0, dotR}, (k < 8) ? {24'b0, ~sel} : 32'hFF);
         chk("scan_dotC", {16'b0, dotC}, 0);
      end
      chk("scan_count", {24'b0, set_count}, 0);

      // Table vectors
      for (int v = 0; v < 9; v++) begin
         logic [15:0] rv;
         handshake(tbl[v].area, tbl[v].idx, tbl[v].op);
         chk("tbl_count", {24'b0, set_count}, tbl[v].exp_cnt);
         read_row(tbl[v].row, rv);
         chk("tbl_row", {16'b0, rv}, {16'b0, tbl[v].exp_row});
      end

      // Clear from IDLE: busy exactly 8 cycles
      handshake(2, 9, 0);
      handshake(6, 3, 0);
      @(negedge div_clk_10k);
      clear_all = 1'b1;
      count_busy(16, n);
      chk("clear_busy", n, 8);
      @(negedge div_clk_10k);
      clear_all = 1'b0;
      model_clear();
      check_frame();

      // Clear requested during ACK is deferred until the handshake ends
      handshake(1, 5, 0);
      handshake(3, 10, 0);
      handshake(4, 12, 2);
      start_req(6, 1, 0);
      chk("pre_clear_count", {24'b0, set_count}, 4);
      @(negedge div_clk_10k);
      clear_all  = 1'b1;
      kb.key_req = 1'b0;
      repeat (3) @(posedge div_clk_10k);
      #1;
      chk("ack_before_clear", {31'b0, kb.key_ack}, 0);
      chk("idle_before_clear", {31'b0, busy}, 0);
      count_busy(15, n);
      chk("deferred_clear_busy", n, 8);
      @(negedge div_clk_10k);
      clear_all = 1'b0;
      model_clear();
      check_frame();

      // Second rising edge during CLEAR queues one more full clear
      handshake(0, 15, 0);
      @(negedge div_clk_10k);
      clear_all = 1'b1;
      repeat (4) @(posedge div_clk_10k);
      @(negedge div_clk_10k);
      clear_all = 1'b0;
      repeat (2) @(posedge div_clk_10k);
      @(negedge div_clk_10k);
      clear_all = 1'b1;
      count_busy(20, n);
      chk("double_clear_busy", n, 12);
      @(negedge div_clk_10k);
      clear_all = 1'b0;
      model_clear();
      check_frame();

      // Randomized writes against the reference array
      for (int t = 0; t < 24; t++) begin
         a   = $urandom_range(7);
         idx = $urandom_range(15);
         op  = $urandom_range(3);
         handshake(a, idx, op);
         chk("rand_count", {24'b0, set_count}, model_count());
         if (t % 8 == 7) check_frame();
      end

      // Reset during ACK
      start_req(3, 3, 0);
      #2;
      reset = 1'b0;
      #1;
      chk("rst_ack_drop", {31'b0, kb.key_ack}, 0);
      chk("rst_mid_dotR", {24'b0, dotR}, 32'hFF);
      chk("rst_mid_dotC", {16'b0, dotC}, 0);
      chk("rst_mid_count", {24'b0, set_count}, 0);
      kb.key_req = 1'b0;
      model_clear();
      @(negedge div_clk_10k);
      reset = 1'b1;
      handshake(7, 0, 0);
      check_frame();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule

// File: doc/mine_map_writer.md
# mine_map_writer

Frame-buffer writer for the 8x16 LED dot matrix in the bomb game. Accepts cell-write requests from the keypad path: a 4-bit cell index plus the 3-bit area from the move FSM, over a 4-phase req/ack handshake. Maps each request to one pixel of a 128-bit frame and scans that frame out to the dot-matrix row/column pins. It is the write side of the matrix interface; the row scanner is its read side.

## Interface
- FRAME_ROWS, 8, matrix rows (scan slots 0..7, plus one blank slot)
- FRAME_COLS, 16, matrix columns
- AREA_DIM, 4, cells per area edge (8 areas = 2 area-rows x 4 area-cols)
- div_clk_10k  in  1  block clock (10 kHz)
- reset  in  1  asynchronous, active-low
- key_req  in  1  4-phase request from the keypad domain (asynchronous; synchronized internally)
- key_index  in  4  cell within area; stable from key_req rise until key_ack rise
- area  in  3  area 0..7; stable under the same rule as key_index
- op  in  2  00 set, 01 clear, 10 toggle, 11 no-op (handshake still completes)
- clear_all  in  1  level request to wipe frame (asynchronous; synchronized, rising-edge detected)
- key_ack  out  1  4-phase acknowledge
- busy  out  1  high in WRITE, ACK, CLEAR
- set_count  out  8  number of lit pixels, 0..128
- dotR  out  8  active-low row select
- dotC  out  16  column data for selected row

## Operation
- Address mapping:
  - ar=area[2], ac=area[1:0], r=key_index[3:2], c=key_index[1:0]
  - row = 4*ar + r, col = 4*ac + c; pixel bit = 16*row + col (0..127)
- Frame stored as 8 row registers of 16 bits.
- key_req and clear_all each pass through 2 flops (req_s, clr_s); clr_rise = clr_s & ~clr_s_d.
- FSM states:
  - IDLE: clr_pend or clr_rise -> CLEAR (clr_pend cleared, clr_row=0); else req_s -> WRITE; clear has priority.
  - WRITE (1 cycle): read-modify-write of the target row per op; set_count updated on the same edge. Set of a lit pixel or clear of a dark pixel leaves set_count unchanged; toggle moves it +/-1. -> ACK.
  - ACK: key_ack=1; stays until req_s=0, then -> IDLE with key_ack=0.
  - CLEAR: zero row clr_row each cycle, clr_row 0..7; on row 7, set_count=0 and -> IDLE.
- clr_rise while in WRITE/ACK/CLEAR sets clr_pend; it is served on the next IDLE.
- clr_rise during CLEAR also sets clr_pend, which causes one further full clear.
- key_req held high through CLEAR is served afterward.
- Scan: slot counter 0..8 wraps. Slot k<8: dotR bit (7-k) low, others high, dotC = frame row k. Slot 8: dotR=8'hFF, dotC=0 (blanking). The scan runs independently of the FSM; dotC reflects writes from the next cycle on.
- Reset values:
  - key_ack=0, busy=0, set_count=0, frame all 0, state IDLE, clr_pend=0
  - slot=0, dotR=8'hFF, dotC=0 while reset is asserted
  - the first slot after reset release is 0

## Timing
- key_req rise to key_ack rise: 4 edges (2 sync, IDLE->WRITE, WRITE->ACK).
- key_req fall to key_ack fall: 3 edges (2 sync, ACK->IDLE).
- Pixel visible on dotC at the next scan of its row: at most 9 cycles after the WRITE edge.
- CLEAR takes exactly 8 cycles; busy is high for all of them.
- set_count is always consistent with the frame at every edge.
- Reset asserted mid-handshake: key_ack drops immediately. The requester must restart with key_req low.

## Structure
- Package mine_map_pkg:
  - state enum {IDLE, WRITE, ACK, CLEAR}
  - op codes OP_SET/OP_CLR/OP_TGL/OP_NOP
  - FRAME_ROWS, FRAME_COLS, AREA_DIM, SCAN_SLOTS=9
- Sub-module dot_row_scan: slot counter plus dotR/dotC mux over the 8 row registers.
- Synchronizers, FSM, address map and counter stay in the top.

## Test plan
- Reset release -> dotR cycles 7F,BF,DF,EF,F7,FB,FD,FE,FF. dotC=0 in every slot, set_count=0.
- area=0, key_index=0, op=set -> key_ack on 4th edge. Row 0 dotC=16'h0001, set_count=1. Drop req -> ack low after 3 edges.
- area=7, key_index=15, op=toggle twice:
  - after the first: row 7 dotC=16'h8000, set_count=1
  - after the second: dotC=0, set_count=0
- area=5, key_index=6, op=set twice -> row 5 dotC=16'h0040 (row 4+1, col 4+2). set_count=1 after the second write, not 2.
- Fill 3 pixels, then pulse clear_all during ACK -> clear starts after ack completes. busy high 8 cycles, all rows 0, set_count=0.
- Assert reset while in ACK -> key_ack=0, frame zeroed, dotR=FF immediately. A new request after release completes normally.
